semaforo_controlador: RTL and testbench
=======================================

Name: semaforo_controlador

Overview:
- Timed traffic-light sequencer: the producing end of the pare/atencao/siga lines that the semaphore display decodes.
- Generates a one-hot light vector in the display's bit order ({siga, atencao, pare} = SWI[2:0] order), so it is never inconsistent.
- Adds a pedestrian request that shortens green, and a maintenance mode that blinks amber.
- Also drives the 7-segment code directly, and exposes the remaining phase time for debug on LED.

Parameters:
- CNT_W, 8, width of the phase counter.
- T_PARE, 8, cycles spent in red.
- T_SIGA, 10, nominal cycles spent in green.
- T_SIGA_MIN, 4, minimum green cycles when a pedestrian request is pending (1 <= T_SIGA_MIN <= T_SIGA).
- T_ATENCAO, 3, cycles spent in amber.
- T_PISCA, 2, half-period of the amber blink in maintenance mode.
- All T_* >= 1 and < 2^CNT_W.

Ports:
- clk_2  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- botao  input  1  pedestrian request (level, sampled each cycle).
- manut  input  1  maintenance mode (blinking amber while high).
- luz  output  3  {siga, atencao, pare}; one-hot, or 000 during the blink-off phase.
- seg  output  8  display code: P=0x73, A=0x77, S=0x6D, blank=0x00.
- pedido_pend  output  1  pedestrian request latched.
- tempo_restante  output  CNT_W  current cnt value; 0 in PISCA.

Behaviour:
- States: PARE, SIGA, ATENCAO, PISCA. All outputs are registered and change on the same clk_2 edge as the state.
- Reset (asynchronous, takes effect immediately, including mid-phase):
  - estado = PARE, cnt = T_PARE-1, luz = 001, seg = 0x73, pedido_pend = 0, fase_pisca = 0, tempo_restante = T_PARE-1.
- Phase counter:
  - On entry to a phase, cnt loads T_x-1, then decrements each cycle.
  - A phase with cnt==0 at an edge transitions on that edge, so each phase lasts exactly T_x cycles.
- Normal sequence: PARE -> SIGA -> ATENCAO -> PARE. Full period = T_PARE+T_SIGA+T_ATENCAO (21 with defaults).
- SIGA early exit:
  - Condition: (cnt==0) OR (pedido_pend AND cnt <= T_SIGA-T_SIGA_MIN).
  - So SIGA lasts >= T_SIGA_MIN cycles when shortened, and exactly T_SIGA otherwise.
- pedido_pend:
  - Sets on any edge where botao==1 and the state is not PARE.
  - Clears on the edge that enters PARE; clear wins over a simultaneous set.
  - botao in PARE is ignored.
  - Request raised in ATENCAO stays latched and is cleared at PARE entry (no effect).
- Maintenance:
  - manut==1 sampled at any edge, in any state, forces the next state to PISCA.
  - Entry into PISCA sets fase_pisca=1 and cnt=T_PISCA-1.
  - While in PISCA: luz=010 / seg=0x77 when fase_pisca=1, and luz=000 / seg=0x00 when 0. fase_pisca toggles and cnt reloads every T_PISCA cycles.
  - manut==0 in PISCA: next state PARE with cnt=T_PARE-1 and pedido_pend cleared.
  - manut has priority over all timer and pedestrian transitions.
- seg per state: PARE 0x73, SIGA 0x6D, ATENCAO 0x77, PISCA as above. seg[7] is never 1 (no inconsistency code is ever produced).
- Counter arithmetic:
  - Unsigned, width CNT_W, never underflows.
  - Comparison uses CNT_W-bit constants computed at elaboration.

Test Plan:
- Free run: reset high 2 cycles, then low, manut=botao=0.
  - Expect luz=001 for 8 cycles, 100 for 10, 010 for 3, then 001 again.
  - tempo_restante counts 7..0 in PARE.
  - seg follows 0x73 / 0x6D / 0x77.
- Early pedestrian request: botao=1 for 1 cycle on SIGA cycle 1.
  - Expect pedido_pend=1 from the next cycle.
  - SIGA lasts 4 cycles, ATENCAO lasts 3.
  - PARE entry clears pedido_pend to 0.
- Late pedestrian request: botao pulse on SIGA cycle 6.
  - Expect SIGA to end after cycle 6 (7 cycles total).
- Request outside SIGA:
  - botao held high throughout PARE: pedido_pend stays 0.
  - botao pulse in ATENCAO cycle 0: pedido_pend=1, cleared at PARE entry; the next SIGA is a full 10 cycles.
- Maintenance: assert manut mid-SIGA (cnt=5).
  - Next cycle luz=010 / seg=0x77 for 2 cycles, then 000 / 0x00 for 2, repeating.
  - Drop manut: next cycle luz=001, tempo_restante=7, PARE lasts 8 cycles.
- Asynchronous reset: assert reset between edges mid-ATENCAO.
  - Expect luz=001, seg=0x73, tempo_restante=7, pedido_pend=0 immediately, without waiting for a clk_2 edge.
  - After release, PARE lasts 8 cycles.

Source files
------------

// File: rtl/semaforo_controlador.sv
// Timed traffic-light sequencer (red/green/amber) with pedestrian shortening of green
// and a blinking-amber maintenance mode; every output is a register updated with the state.
module semaforo_controlador #(
    parameter int CNT_W      = 8,
    parameter int T_PARE     = 8,
    parameter int T_SIGA     = 10,
    parameter int T_SIGA_MIN = 4,
    parameter int T_ATENCAO  = 3,
    parameter int T_PISCA    = 2
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic             botao,
    input  logic             manut,
    output logic [2:0]       luz,
    output logic [7:0]       seg,
    output logic             pedido_pend,
    output logic [CNT_W-1:0] tempo_restante
);

    localparam logic [1:0] PARE    = 2'd0;
    localparam logic [1:0] SIGA    = 2'd1;
    localparam logic [1:0] ATENCAO = 2'd2;
    localparam logic [1:0] PISCA   = 2'd3;

    localparam logic [CNT_W-1:0] LD_PARE     = CNT_W'(T_PARE - 1);
    localparam logic [CNT_W-1:0] LD_SIGA     = CNT_W'(T_SIGA - 1);
    localparam logic [CNT_W-1:0] LD_ATENCAO  = CNT_W'(T_ATENCAO - 1);
    localparam logic [CNT_W-1:0] LD_PISCA    = CNT_W'(T_PISCA - 1);
    localparam logic [CNT_W-1:0] SIGA_LIMIAR = CNT_W'(T_SIGA - T_SIGA_MIN);
    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
    localparam logic [CNT_W-1:0] CNT_UM      = CNT_W'(1);

    localparam logic [7:0] SEG_P   = 8'h73;
    localparam logic [7:0] SEG_A   = 8'h77;
    localparam logic [7:0] SEG_S   = 8'h6D;
    localparam logic [7:0] SEG_OFF = 8'h00;

    logic [1:0]       estado_q, estado_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fase_pisca_q, fase_pisca_d;
    logic             pedido_pend_q, pedido_pend_d;
    logic [2:0]       luz_q, luz_d;
    logic [7:0]       seg_q, seg_d;
    logic [CNT_W-1:0] tempo_q, tempo_d;

    // Every branch that reaches cnt==0 reloads, so the default decrement never wraps.
    always_comb begin
        estado_d     = estado_q;
        cnt_d        = cnt_q - CNT_UM;
        fase_pisca_d = fase_pisca_q;
        if (manut) begin
            if (estado_q != PISCA) begin
                estado_d     = PISCA;
                cnt_d        = LD_PISCA;
                fase_pisca_d = 1'b1;
            end else if (cnt_q == CNT_ZERO) begin
                cnt_d        = LD_PISCA;
                fase_pisca_d = ~fase_pisca_q;
            end
        end else begin
            case (estado_q)
                PARE: begin
                    if (cnt_q == CNT_ZERO) begin
                        estado_d = SIGA;
                        cnt_d    = LD_SIGA;
                    end
                end
                SIGA: begin
                    if ((cnt_q == CNT_ZERO) || (pedido_pend_q && (cnt_q <= SIGA_LIMIAR))) begin
                        estado_d = ATENCAO;
                        cnt_d    = LD_ATENCAO;
                    end
                end
                ATENCAO: begin
                    if (cnt_q == CNT_ZERO) begin
                        estado_d = PARE;
                        cnt_d    = LD_PARE;
                    end
                end
                default: begin
                    estado_d = PARE;
                    cnt_d    = LD_PARE;
                end
            endcase
        end
    end

    // Entering red clears the request even if botao is high on the same edge.
    always_comb begin
        pedido_pend_d = pedido_pend_q;
        if (botao && (estado_q != PARE)) begin
            pedido_pend_d = 1'b1;
        end
        if ((estado_d == PARE) && (estado_q != PARE)) begin
            pedido_pend_d = 1'b0;
        end
    end

    always_comb begin
        luz_d   = 3'b001;
        seg_d   = SEG_P;
        tempo_d = cnt_d;
        case (estado_d)
            SIGA: begin
                luz_d = 3'b100;
                seg_d = SEG_S;
            end
            ATENCAO: begin
                luz_d = 3'b010;
                seg_d = SEG_A;
            end
            PISCA: begin
                luz_d   = fase_pisca_d ? 3'b010 : 3'b000;
                seg_d   = fase_pisca_d ? SEG_A : SEG_OFF;
                tempo_d = CNT_ZERO;
            end
            default: begin
                luz_d = 3'b001;
                seg_d = SEG_P;
            end
        endcase
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            estado_q      <= PARE;
            cnt_q         <= LD_PARE;
            fase_pisca_q  <= 1'b0;
            pedido_pend_q <= 1'b0;
            luz_q         <= 3'b001;
            seg_q         <= SEG_P;
            tempo_q       <= LD_PARE;
        end else begin
            estado_q      <= estado_d;
            cnt_q         <= cnt_d;
            fase_pisca_q  <= fase_pisca_d;
            pedido_pend_q <= pedido_pend_d;
            luz_q         <= luz_d;
            seg_q         <= seg_d;
            tempo_q       <= tempo_d;
        end
    end

    assign luz            = luz_q;
    assign seg            = seg_q;
    assign pedido_pend    = pedido_pend_q;
    assign tempo_restante = tempo_q;

endmodule

// File: tb/tb_semaforo_controlador.sv
// Scoreboard bench for semaforo_controlador: the driver queues hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the DUT outputs.
module tb_semaforo_controlador;

    localparam int CNT_W = 8;

    logic             clk_2;
    logic             reset;
    logic             botao;
    logic             manut;
    logic [2:0]       luz;
    logic [7:0]       seg;
    logic             pedido_pend;
    logic [CNT_W-1:0] tempo_restante;

    typedef struct packed {
        logic [2:0]       luz;
        logic [7:0]       seg;
        logic             pend;
        logic [CNT_W-1:0] tempo;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_cyc   = 0;

    semaforo_controlador #(
        .CNT_W(CNT_W), .T_PARE(8), .T_SIGA(10), .T_SIGA_MIN(4),
        .T_ATENCAO(3), .T_PISCA(2)
    ) dut (
        .clk_2         (clk_2),
        .reset         (reset),
        .botao         (botao),
        .manut         (manut),
        .luz           (luz),
        .seg           (seg),
        .pedido_pend   (pedido_pend),
        .tempo_restante(tempo_restante)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    // Monitor: outputs are valid every cycle, compared mid-cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_2);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                n_cyc++;
                if (luz !== e.luz || seg !== e.seg || pedido_pend !== e.pend || tempo_restante !== e.tempo) begin
                    n_fail++;
                    $display("[TB] FAIL cycle%0d: got luz=%b seg=%h pend=%b tempo=%0d, want luz=%b seg=%h pend=%b tempo=%0d",
                             n_cyc, luz, seg, pedido_pend, tempo_restante, e.luz, e.seg, e.pend, e.tempo);
                end else begin
                    $display("[TB] cycle%0d ok: luz=%b seg=%h pend=%b tempo=%0d",
                             n_cyc, luz, seg, pedido_pend, tempo_restante);
                end
            end
        end
    end

    // Push the expectation for the cycle just started, then set inputs sampled at its end.
    task automatic tick(input logic b, input logic m, input logic r, input logic [2:0] l,
                        input logic [7:0] s, input logic p, input logic [CNT_W-1:0] t);
        exp_t e;
        @(posedge clk_2);
        #1;
        e.luz   = l;
        e.seg   = s;
        e.pend  = p;
        e.tempo = t;
        exp_q.push_back(e);
        botao = b;
        manut = m;
        reset = r;
    endtask

    // bot_at: phase cycle with botao high (-2 = all, -1 = none); pend expected from pend_from (-1 = never).
    task automatic phase(input logic [2:0] l, input logic [7:0] s, input int t0, input int n,
                         input int bot_at, input int pend_from, input int man_at);
        for (int i = 0; i < n; i++) begin
            tick((bot_at == -2) || (bot_at == i), man_at == i, 1'b0, l, s,
                 (pend_from >= 0) && (i >= pend_from), CNT_W'(t0 - i));
        end
    endtask

    task automatic pare_full(input int bot_at);
        phase(3'b001, 8'h73, 7, 8, bot_at, -1, -1);
    endtask

    task automatic siga_full();
        phase(3'b100, 8'h6D, 9, 10, -1, -1, -1);
    endtask

    task automatic atencao(input int bot_at, input int pend_from);
        phase(3'b010, 8'h77, 2, 3, bot_at, pend_from, -1);
    endtask

    initial begin
        exp_t e;
        reset = 1'b1;
        botao = 1'b0;
        manut = 1'b0;

        // Free run: two reset cycles (the last one is PARE's cnt=7 cycle), then 7..0
        tick(1'b0, 1'b0, 1'b1, 3'b001, 8'h73, 1'b0, 8'd7);
        tick(1'b0, 1'b0, 1'b0, 3'b001, 8'h73, 1'b0, 8'd7);
        phase(3'b001, 8'h73, 6, 7, -1, -1, -1);
        siga_full();
        atencao(-1, -1);

        // Early request on green's first cycle: green shortened to 4 cycles
        pare_full(-1);
        phase(3'b100, 8'h6D, 9, 4, 0, 1, -1);
        atencao(-1, 0);

        // Late request on green's sixth cycle: green lasts 7 cycles
        pare_full(-1);
        phase(3'b100, 8'h6D, 9, 7, 5, 6, -1);
        atencao(-1, 0);

        // botao held through red is ignored; a request in amber only lingers until red
        pare_full(-2);
        siga_full();
        atencao(0, 1);
        pare_full(-1);
        siga_full();
        atencao(-1, -1);

        // Maintenance raised at green cnt=5, blink 2 on / 2 off, then back to a full red
        pare_full(-1);
        phase(3'b100, 8'h6D, 9, 5, -1, -1, 4);
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, k < 7, 1'b0, ((k / 2) % 2 == 0) ? 3'b010 : 3'b000,
                 ((k / 2) % 2 == 0) ? 8'h77 : 8'h00, 1'b0, 8'd0);
        end
        pare_full(-1);
        siga_full();

        // Asynchronous reset landing between edges in amber's second cycle
        phase(3'b010, 8'h77, 2, 1, -1, -1, -1);
        @(posedge clk_2);
        #2;
        reset = 1'b1;
        e.luz   = 3'b001;
        e.seg   = 8'h73;
        e.pend  = 1'b0;
        e.tempo = 8'd7;
        exp_q.push_back(e);
        tick(1'b0, 1'b0, 1'b0, 3'b001, 8'h73, 1'b0, 8'd7);
        phase(3'b001, 8'h73, 6, 7, -1, -1, -1);
        phase(3'b100, 8'h6D, 9, 2, -1, -1, -1);

        repeat (3) @(negedge clk_2);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
